// File: rtl/ccc_lock_reset_seq_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ccc_lock_reset_seq_if
// Purpose  : Bundles the lock inputs, the loss-clear pulse and the reset and
//            status outputs of the capture-fabric reset sequencer.
// Ports    : master - drives fab_lock, mss_lock, clr_loss; observes outputs
//            slave  - the sequencer side (consumes inputs, drives outputs)
// Revision : 1.0 - initial release
// ============================================================================
interface ccc_lock_reset_seq_if;
    logic       fab_lock;   // CCC fabric PLL lock, asynchronous
    logic       mss_lock;   // CCC MSS PLL lock, asynchronous
    logic       clr_loss;   // one-cycle pulse, clears loss flag and count
    logic       fab_rst;    // active-high reset to capture logic
    logic       fab_rst_n;  // registered complement of fab_rst
    logic       ready;      // high only in RUN
    logic       lock_lost;  // sticky lock-loss flag
    logic [7:0] loss_cnt;   // saturating lock-loss count
    logic [1:0] state;      // debug state encoding

    modport master (
        output fab_lock, mss_lock, clr_loss,
        input  fab_rst, fab_rst_n, ready, lock_lost, loss_cnt, state
    );

    modport slave (
        input  fab_lock, mss_lock, clr_loss,
        output fab_rst, fab_rst_n, ready, lock_lost, loss_cnt, state
    );
endinterface
`default_nettype wire

// File: rtl/ccc_lock_reset_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ccc_lock_reset_seq
// Purpose  : Holds the capture fabric in reset until the PLL lock indication
//            has been stable for LOCK_HOLD cycles plus RST_HOLD cycles, then
//            releases reset synchronously. Any lock loss re-asserts reset;
//            losses from RUN are flagged and counted (saturating at 255).
// Ports    : clk  - CCC fabric clock
//            rst  - asynchronous active-high reset
//            bus  - slave modport: fab_lock, mss_lock, clr_loss in;
//                   fab_rst, fab_rst_n, ready, lock_lost, loss_cnt, state out
// Revision : 1.0 - initial release
// ============================================================================
module ccc_lock_reset_seq #(
    parameter int SYNC_STAGES  = 2,
    parameter int LOCK_HOLD    = 1024,
    parameter int RST_HOLD     = 16,
    parameter int USE_MSS_LOCK = 1
) (
    input  wire logic            clk,
    input  wire logic            rst,
    ccc_lock_reset_seq_if.slave  bus
);

    localparam logic [1:0]  c_ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0]  c_ST_DEBOUNCE  = 2'd1;
    localparam logic [1:0]  c_ST_HOLD      = 2'd2;
    localparam logic [1:0]  c_ST_RUN       = 2'd3;

    localparam logic [15:0] c_LOCK_TERM    = 16'(LOCK_HOLD - 1);
    localparam logic [15:0] c_RST_TERM     = 16'(RST_HOLD - 1);
    localparam logic [7:0]  c_LOSS_MAX     = 8'hFF;
    localparam logic        c_IGNORE_MSS   = (USE_MSS_LOCK == 0);

    // ------------------------------------------------------------------
    // Lock synchronizers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_fab_sync;
    logic [SYNC_STAGES-1:0] r_mss_sync;
    logic                   w_lock_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fab_sync <= '0;
            r_mss_sync <= '0;
        end else begin
            r_fab_sync <= {r_fab_sync[SYNC_STAGES-2:0], bus.fab_lock};
            r_mss_sync <= {r_mss_sync[SYNC_STAGES-2:0], bus.mss_lock};
        end
    end

    // With MSS qualification disabled the MSS term is forced true, so the
    // MSS chain still exists but never gates lock_ok.
    assign w_lock_ok = r_fab_sync[SYNC_STAGES-1]
                     & (r_mss_sync[SYNC_STAGES-1] | c_IGNORE_MSS);

    // ------------------------------------------------------------------
    // FSM state and registered outputs
    // ------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [15:0] r_cnt;
    logic        r_fab_rst;
    logic        r_fab_rst_n;
    logic        r_ready;
    logic        r_lock_lost;
    logic [7:0]  r_loss_cnt;

    logic [1:0]  w_state_nxt;
    logic [15:0] w_cnt_nxt;
    logic        w_loss_evt;
    logic        w_run_nxt;
    logic        w_lock_lost_nxt;
    logic [7:0]  w_loss_cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_WAIT_LOCK;
            r_cnt       <= '0;
            r_fab_rst   <= 1'b1;
            r_fab_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
            r_loss_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_fab_rst   <= ~w_run_nxt;
            r_fab_rst_n <= w_run_nxt;
            r_ready     <= w_run_nxt;
            r_lock_lost <= w_lock_lost_nxt;
            r_loss_cnt  <= w_loss_cnt_nxt;
        end
    end

    // Next-state logic. The shared counter restarts from zero whenever the
    // state changes, so each phase counts its own cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_loss_evt  = 1'b0;
        case (r_state)
            c_ST_WAIT_LOCK: begin
                w_cnt_nxt = '0;
                if (w_lock_ok) begin
                    w_state_nxt = c_ST_DEBOUNCE;
                end
            end
            c_ST_DEBOUNCE: begin
                if (!w_lock_ok) begin
                    w_state_nxt = c_ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_LOCK_TERM) begin
                    w_state_nxt = c_ST_HOLD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            c_ST_HOLD: begin
                if (!w_lock_ok) begin
                    w_state_nxt = c_ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_RST_TERM) begin
                    w_state_nxt = c_ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            c_ST_RUN: begin
                w_cnt_nxt = '0;
                if (!w_lock_ok) begin
                    w_state_nxt = c_ST_WAIT_LOCK;
                    w_loss_evt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_WAIT_LOCK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode from next state. A loss event takes priority over a
    // coincident clear, leaving the count at one.
    always_comb begin
        w_run_nxt       = (w_state_nxt == c_ST_RUN);
        w_lock_lost_nxt = r_lock_lost;
        w_loss_cnt_nxt  = r_loss_cnt;
        if (w_loss_evt) begin
            w_lock_lost_nxt = 1'b1;
            if (bus.clr_loss) begin
                w_loss_cnt_nxt = 8'd1;
            end else if (r_loss_cnt != c_LOSS_MAX) begin
                w_loss_cnt_nxt = r_loss_cnt + 8'd1;
            end
        end else if (bus.clr_loss) begin
            w_lock_lost_nxt = 1'b0;
            w_loss_cnt_nxt  = '0;
        end
    end

    assign bus.fab_rst   = r_fab_rst;
    assign bus.fab_rst_n = r_fab_rst_n;
    assign bus.ready     = r_ready;
    assign bus.lock_lost = r_lock_lost;
    assign bus.loss_cnt  = r_loss_cnt;
    assign bus.state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ccc_lock_reset_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ccc_lock_reset_seq
// Purpose  : Self-checking bench for ccc_lock_reset_seq. Two instances share
//            the lock inputs: u_dut0 qualifies on fab & mss, u_dut1 on fab
//            only. A run-length reference model predicts every output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ccc_lock_reset_seq;

    localparam int SS     = 2;
    localparam int LH     = 8;
    localparam int RH     = 4;
    localparam int RUN_AT = LH + RH;   // run length above this means RUN

    logic clk = 1'b0;
    logic rst;
    logic fab = 1'b0;
    logic mss = 1'b0;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    ccc_lock_reset_seq_if if0 ();
    ccc_lock_reset_seq_if if1 ();

    assign if0.fab_lock = fab;
    assign if0.mss_lock = mss;
    assign if0.clr_loss = clr;
    assign if1.fab_lock = fab;
    assign if1.mss_lock = mss;
    assign if1.clr_loss = clr;

    ccc_lock_reset_seq #(.SYNC_STAGES(SS), .LOCK_HOLD(LH), .RST_HOLD(RH), .USE_MSS_LOCK(1))
        u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    ccc_lock_reset_seq #(.SYNC_STAGES(SS), .LOCK_HOLD(LH), .RST_HOLD(RH), .USE_MSS_LOCK(0))
        u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------
    // Reference model: the FSM sees raw lock SS edges late; the state is a
    // pure function of how many consecutive qualified edges it has seen.
    // ------------------------------------------------------------------
    bit fh [SS];
    bit mh [SS];
    int run_m  [2];
    bit lost_m [2];
    int cnt_m  [2];

    always @(posedge clk or posedge rst) begin
        bit vf, vm, ok, loss;
        if (rst) begin
            for (int i = 0; i < SS; i++) begin
                fh[i] = 1'b0;
                mh[i] = 1'b0;
            end
            for (int m = 0; m < 2; m++) begin
                run_m[m]  = 0;
                lost_m[m] = 1'b0;
                cnt_m[m]  = 0;
            end
        end else begin
            vf = fh[SS-1];
            vm = mh[SS-1];
            for (int i = SS - 1; i > 0; i--) begin
                fh[i] = fh[i-1];
                mh[i] = mh[i-1];
            end
            fh[0] = fab;
            mh[0] = mss;
            for (int m = 0; m < 2; m++) begin
                ok   = vf & ((m == 0) ? vm : 1'b1);
                loss = !ok && (run_m[m] > RUN_AT);
                if (loss) begin
                    lost_m[m] = 1'b1;
                    cnt_m[m]  = clr ? 1 : ((cnt_m[m] < 255) ? cnt_m[m] + 1 : 255);
                end else if (clr) begin
                    lost_m[m] = 1'b0;
                    cnt_m[m]  = 0;
                end
                if (!ok)
                    run_m[m] = 0;
                else if (run_m[m] <= RUN_AT)
                    run_m[m] = run_m[m] + 1;
            end
        end
    end

    function automatic int mstate(int r);
        if (r == 0)      return 0;
        if (r <= LH)     return 1;
        if (r <= RUN_AT) return 2;
        return 3;
    endfunction

    // Expected state e edges after lock first captured (from WAIT_LOCK).
    function automatic int qual(int e);
        if (e < SS)           return 0;
        if (e < SS + LH)      return 1;
        if (e < SS + LH + RH) return 2;
        return 3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int s0, s1;
        s0 = mstate(run_m[0]);
        s1 = mstate(run_m[1]);
        chk("m0.state",     32'(if0.state),     s0);
        chk("m0.fab_rst",   32'(if0.fab_rst),   (s0 != 3) ? 1 : 0);
        chk("m0.fab_rst_n", 32'(if0.fab_rst_n), (s0 == 3) ? 1 : 0);
        chk("m0.ready",     32'(if0.ready),     (s0 == 3) ? 1 : 0);
        chk("m0.lock_lost", 32'(if0.lock_lost), 32'(lost_m[0]));
        chk("m0.loss_cnt",  32'(if0.loss_cnt),  cnt_m[0]);
        chk("m1.state",     32'(if1.state),     s1);
        chk("m1.fab_rst",   32'(if1.fab_rst),   (s1 != 3) ? 1 : 0);
        chk("m1.fab_rst_n", 32'(if1.fab_rst_n), (s1 == 3) ? 1 : 0);
        chk("m1.ready",     32'(if1.ready),     (s1 == 3) ? 1 : 0);
        chk("m1.lock_lost", 32'(if1.lock_lost), 32'(lost_m[1]));
        chk("m1.loss_cnt",  32'(if1.loss_cnt),  cnt_m[1]);
    endtask

    // Drive inputs on the falling edge, let one rising edge sample them,
    // then compare against the model 1 ns later.
    task automatic step(input bit f, input bit m, input bit c);
        @(negedge clk);
        fab = f;
        mss = m;
        clr = c;
        @(posedge clk);
        #1;
        check_model();
    endtask

    // Async reset in the middle of a clock phase, then a timed release.
    task automatic rst_mid(input string tag);
        int k;
        #2 rst = 1'b1;
        #1;
        chk({tag, ".fab_rst"},   32'(if0.fab_rst),   1);
        chk({tag, ".fab_rst_n"}, 32'(if0.fab_rst_n), 0);
        chk({tag, ".ready"},     32'(if0.ready),     0);
        chk({tag, ".state"},     32'(if0.state),     0);
        chk({tag, ".loss_cnt"},  32'(if0.loss_cnt),  0);
        chk({tag, ".lock_lost"}, 32'(if0.lock_lost), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        k = 0;
        while (k < 40) begin
            step(1, 1, 0);
            if (!if0.fab_rst) break;
            k++;
        end
        chk({tag, ".release_edge"}, k, SS + LH + RH);
    endtask

    typedef struct {
        bit fl;
        bit ml;
        bit clr;
        int st0;
        int st1;
        int cnt0;
        int lost0;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit fl, bit ml, bit c, int st0, int st1, int cnt0, int lost0);
        vec_t v;
        v.fl = fl; v.ml = ml; v.clr = c;
        v.st0 = st0; v.st1 = st1; v.cnt0 = cnt0; v.lost0 = lost0;
        tbl.push_back(v);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int hold;
        bit rf, rm;

        // Basic qualification from WAIT_LOCK
        for (int e = 0; e < 16; e++) add(1, 1, 0, qual(e), qual(e), 0, 0);
        // MSS drop from RUN: only the MSS-qualified instance reacts
        add(1, 0, 0, 3, 3, 0, 0);
        add(1, 0, 0, 3, 3, 0, 0);
        add(1, 0, 0, 0, 3, 1, 1);
        for (int e = 0; e < 16; e++) add(1, 1, 0, qual(e), 3, 1, 1);
        // Clear coincident with a loss: the loss wins
        add(1, 0, 0, 3, 3, 1, 1);
        add(1, 0, 0, 3, 3, 1, 1);
        add(1, 0, 1, 0, 3, 1, 1);
        for (int e = 0; e < 16; e++) add(1, 1, 0, qual(e), 3, 1, 1);
        // Plain clear pulse
        add(1, 1, 1, 3, 3, 0, 0);
        add(1, 1, 0, 3, 3, 0, 0);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.fab_rst",   32'(if0.fab_rst),   1);
        chk("reset.fab_rst_n", 32'(if0.fab_rst_n), 0);
        chk("reset.ready",     32'(if0.ready),     0);
        chk("reset.state",     32'(if0.state),     0);
        chk("reset.loss_cnt",  32'(if0.loss_cnt),  0);
        chk("reset.lock_lost", 32'(if0.lock_lost), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step(0, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].fl, tbl[i].ml, tbl[i].clr);
            chk($sformatf("tbl[%0d].state0", i),   32'(if0.state),     tbl[i].st0);
            chk($sformatf("tbl[%0d].fab_rst0", i), 32'(if0.fab_rst),   (tbl[i].st0 != 3) ? 1 : 0);
            chk($sformatf("tbl[%0d].ready0", i),   32'(if0.ready),     (tbl[i].st0 == 3) ? 1 : 0);
            chk($sformatf("tbl[%0d].cnt0", i),     32'(if0.loss_cnt),  tbl[i].cnt0);
            chk($sformatf("tbl[%0d].lost0", i),    32'(if0.lock_lost), tbl[i].lost0);
            chk($sformatf("tbl[%0d].state1", i),   32'(if1.state),     tbl[i].st1);
            chk($sformatf("tbl[%0d].cnt1", i),     32'(if1.loss_cnt),  0);
        end

        // Lock loss from RUN (counted once), then a 1-cycle FAB glitch in
        // DEBOUNCE which restarts qualification without being counted.
        repeat (4) step(0, 0, 0);
        for (int e = 0; e < 25; e++) begin
            step((e == 6) ? 1'b0 : 1'b1, 1'b1, 1'b0);
            if (e == 8)  chk("glitch.state_wait", 32'(if0.state), 0);
            if (e == 21) chk("glitch.state_run",  32'(if0.state), 3);
            chk($sformatf("glitch[%0d].fab_rst", e), 32'(if0.fab_rst), (e >= 21) ? 0 : 1);
        end
        chk("glitch.loss_cnt", 32'(if0.loss_cnt), 1);

        // Saturation: 260 loss/relock cycles
        for (int i = 0; i < 260; i++) begin
            step(1, 0, 0);
            step(1, 1, 0);
            step(1, 1, 0);
            k = 0;
            while (!if0.ready && k < 40) begin
                step(1, 1, 0);
                k++;
            end
            if (k >= 40) begin
                chk("sat.relock_timeout", k, 0);
                break;
            end
        end
        chk("sat.loss_cnt",  32'(if0.loss_cnt),  255);
        chk("sat.lock_lost", 32'(if0.lock_lost), 1);
        step(1, 1, 1);
        chk("sat.clr_cnt",  32'(if0.loss_cnt),  0);
        chk("sat.clr_lost", 32'(if0.lock_lost), 0);
        step(1, 1, 0);

        // Reset mid-operation: in HOLD (after one counted loss), then in RUN
        repeat (3) step(0, 0, 0);
        chk("pre_hold.loss_cnt", 32'(if0.loss_cnt), 1);
        for (int e = 0; e < 12; e++) step(1, 1, 0);
        chk("pre_hold.state", 32'(if0.state), 2);
        rst_mid("rst_hold");
        chk("pre_run.state", 32'(if0.state), 3);
        rst_mid("rst_run");

        // Randomized lock activity, clears and rare async resets
        hold = 0;
        rf = 1'b0;
        rm = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                rf   = ($urandom_range(0, 3) != 0);
                rm   = ($urandom_range(0, 3) != 0);
                hold = $urandom_range(1, 40);
            end
            hold--;
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
            step(rf, rm, ($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
